// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter sharing one uart_tx serializer between NUM_REQ
//   byte-stream requesters. A granted requester keeps the serializer until it
//   delivers a byte flagged last, or until it stays idle in SEND for
//   IDLE_TIMEOUT cycles, which revokes the grant with a pkt_abort pulse.
//
// Ports
//   clk, resetn        : clock, asynchronous active-low reset
//   req_valid[i]       : requester i presents a byte
//   req_data           : requester i byte at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   req_last[i]        : presented byte ends its packet
//   req_ready[i]       : byte accepted this cycle (combinational)
//   grant              : one-hot serializer owner, zero when free
//   pkt_abort          : one-cycle pulse when a grant is revoked by timeout
//   uart_tx_busy       : serializer busy, rises the cycle after uart_tx_en
//   uart_tx_en         : one-cycle send strobe
//   uart_tx_data       : byte to send, held until uart_tx_busy falls
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int PAYLOAD_BITS = 8,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
   input  logic [NUM_REQ-1:0]              req_last,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [NUM_REQ-1:0]              grant,
   output logic                            pkt_abort,
   input  logic                            uart_tx_busy,
   output logic                            uart_tx_en,
   output logic [PAYLOAD_BITS-1:0]         uart_tx_data
);

   localparam int                IDX_W    = $clog2(NUM_REQ);
   localparam int                CNT_W    = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W:0]    NREQ_EXT = (IDX_W + 1)'(NUM_REQ);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [1:0] {ARB, SEND, WAIT_HI, WAIT_LO} state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        ptr_q, ptr_d;
   logic [IDX_W-1:0]        gidx_q, gidx_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic [CNT_W-1:0]        idle_q, idle_d;
   logic                    last_q, last_d;
   logic                    en_q, en_d;
   logic                    abort_q, abort_d;
   logic [PAYLOAD_BITS-1:0] data_q, data_d;

   logic [IDX_W:0]          rr_sum;
   logic [IDX_W-1:0]        pick;
   logic                    pick_vld;
   logic [IDX_W-1:0]        gnext;
   logic                    xfer;

   // Round-robin pick: scan from the highest index offset down so the
   // lowest offset from ptr that is valid overwrites and wins.
   always_comb begin
      rr_sum   = '0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         rr_sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
         if (rr_sum >= NREQ_EXT) rr_sum = rr_sum - NREQ_EXT;
         if (req_valid[rr_sum[IDX_W-1:0]]) begin
            pick     = rr_sum[IDX_W-1:0];
            pick_vld = 1'b1;
         end
      end
   end

   assign gnext = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
   assign xfer  = (state_q == SEND) & req_valid[gidx_q] & ~uart_tx_busy;

   // Only the owner can see ready, and only while a transfer is possible.
   assign req_ready = grant_q & {NUM_REQ{xfer}};

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      grant_d = grant_q;
      idle_d  = idle_q;
      last_d  = last_q;
      data_d  = data_q;
      en_d    = 1'b0;
      abort_d = 1'b0;
      case (state_q)
         ARB: begin
            if (pick_vld) begin
               gidx_d  = pick;
               grant_d = ONE_HOT0 << pick;
               idle_d  = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               data_d  = req_data[gidx_q*PAYLOAD_BITS +: PAYLOAD_BITS];
               last_d  = req_last[gidx_q];
               en_d    = 1'b1;
               state_d = WAIT_HI;
            end else if (idle_q == CNT_LAST) begin
               // This is the IDLE_TIMEOUT-th cycle without a transfer.
               abort_d = 1'b1;
               grant_d = '0;
               ptr_d   = gnext;
               state_d = ARB;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         WAIT_HI: begin
            if (uart_tx_busy) state_d = WAIT_LO;
         end
         WAIT_LO: begin
            if (!uart_tx_busy) begin
               if (last_q) begin
                  grant_d = '0;
                  ptr_d   = gnext;
                  state_d = ARB;
               end else begin
                  idle_d  = '0;
                  state_d = SEND;
               end
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ARB;
         ptr_q   <= '0;
         gidx_q  <= '0;
         grant_q <= '0;
         idle_q  <= '0;
         last_q  <= 1'b0;
         en_q    <= 1'b0;
         abort_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         grant_q <= grant_d;
         idle_q  <= idle_d;
         last_q  <= last_d;
         en_q    <= en_d;
         abort_q <= abort_d;
         data_q  <= data_d;
      end
   end

   assign grant        = grant_q;
   assign pkt_abort    = abort_q;
   assign uart_tx_en   = en_q;
   assign uart_tx_data = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Requesters are byte queues; uart_tx is emulated by a busy counter. A
//   packet-level round-robin model predicts the order of strobed bytes and
//   their owner; per-cycle rules cover the strobe, ready and abort behaviour.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int PB = 8;
   localparam int TO = 8;

   logic               clk = 1'b0;
   logic               resetn = 1'b0;
   logic [NR-1:0]      req_valid;
   logic [NR*PB-1:0]   req_data;
   logic [NR-1:0]      req_last;
   logic [NR-1:0]      req_ready;
   logic [NR-1:0]      grant;
   logic               pkt_abort;
   logic               uart_tx_busy;
   logic               uart_tx_en;
   logic [PB-1:0]      uart_tx_data;

   uart_tx_arbiter #(.NUM_REQ(NR), .PAYLOAD_BITS(PB), .IDLE_TIMEOUT(TO)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .grant        (grant),
      .pkt_abort    (pkt_abort),
      .uart_tx_busy (uart_tx_busy),
      .uart_tx_en   (uart_tx_en),
      .uart_tx_data (uart_tx_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Requester queues: {last, byte}
   logic [8:0]    mem [NR][64];
   int            head [NR];
   int            tail [NR];
   logic [11:0]   expq [$];
   logic [NR-1:0] sg_log [$];
   int            gap_run [NR];
   logic [NR-1:0] gap_now = '0;

   int   mptr = 0;
   int   cyc = 0;
   int   bcnt = 0;
   int   blen = 3;
   bit   blen_rand = 0;
   bit   gaps_on = 0;
   int   last_fall = -100;
   int   exp_abort = -1;
   bit   arm_abort = 0;
   bit   lat_chk = 0;
   int   pkt_strobes = 0;
   logic [PB-1:0] last_data = '0;
   logic          s_en;
   logic [NR-1:0] s_grant, s_ready;

   function automatic void push(input int i, input logic [7:0] b, input logic l);
      mem[i][tail[i]] = {l, b};
      tail[i]++;
   endfunction

   // Packet-level round robin: whole packets, owner chosen from mptr onward.
   function automatic void plan();
      int  h [NR];
      int  sel;
      bit  found;
      bit  lst;
      for (int i = 0; i < NR; i++) h[i] = head[i];
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         sel   = 0;
         for (int k = 0; k < NR; k++) begin
            if (!found && h[(mptr + k) % NR] < tail[(mptr + k) % NR]) begin
               found = 1'b1;
               sel   = (mptr + k) % NR;
            end
         end
         if (found) begin
            lst = 1'b0;
            while (!lst && h[sel] < tail[sel]) begin
               expq.push_back({4'(sel), mem[sel][h[sel]][7:0]});
               lst = mem[sel][h[sel]][8];
               h[sel]++;
            end
            mptr = (sel + 1) % NR;
         end
      end
   endfunction

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         if (head[i] < tail[i] && !gap_now[i]) begin
            req_valid[i]        = 1'b1;
            req_data[i*PB +: PB] = mem[i][head[i]][7:0];
            req_last[i]         = mem[i][head[i]][8];
         end else begin
            req_valid[i]        = 1'b0;
            req_data[i*PB +: PB] = '0;
            req_last[i]         = 1'b0;
         end
      end
   endtask

   task automatic tick();
      logic [NR-1:0] xfer;
      logic [11:0]   e;
      logic          nb;
      @(negedge clk);
      xfer = req_valid & req_ready;
      check("pkt_abort", 32'(pkt_abort), 32'(cyc == exp_abort));
      if (cyc == exp_abort) check("abort_grant", 32'(grant), 0);
      check("grant_onehot", 32'($countones(grant) <= 1), 1);
      if (uart_tx_busy) begin
         check("ready_busy", 32'(req_ready), 0);
         check("data_hold", 32'(uart_tx_data), 32'(last_data));
      end
      if (uart_tx_en) begin
         check("en_busy", 32'(uart_tx_busy), 0);
         if (expq.size() == 0) begin
            check("stray_en", 32'(uart_tx_en), 0);
         end else begin
            e = expq.pop_front();
            check("tx_data", 32'(uart_tx_data), 32'(e[7:0]));
            check("tx_grant", 32'(grant), 32'(1) << e[11:8]);
         end
         if (lat_chk && pkt_strobes > 0) check("strobe_lat", cyc - last_fall, 2);
         pkt_strobes++;
         sg_log.push_back(grant);
         last_data = uart_tx_data;
      end
      s_en    = uart_tx_en;
      s_grant = grant;
      s_ready = req_ready;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NR; i++) if (xfer[i]) head[i]++;
      if (s_en) bcnt = blen_rand ? int'($urandom_range(1, 6)) : blen;
      nb = (bcnt > 0);
      if (bcnt > 0) bcnt--;
      if (uart_tx_busy && !nb) begin
         last_fall = cyc;
         if (arm_abort) begin
            exp_abort = cyc + TO + 1;
            arm_abort = 0;
         end
      end
      uart_tx_busy = nb;
      for (int i = 0; i < NR; i++) begin
         if (gaps_on && grant[i] && gap_run[i] < 3 && $urandom_range(0, 3) == 0) begin
            gap_now[i] = 1'b1;
            gap_run[i]++;
         end else begin
            gap_now[i] = 1'b0;
            gap_run[i] = 0;
         end
      end
      drive();
   endtask

   function automatic bit idle_now();
      bit r;
      r = (expq.size() == 0) && (grant == '0) && !uart_tx_busy && (bcnt == 0)
          && (exp_abort < cyc) && !arm_abort;
      for (int i = 0; i < NR; i++) if (head[i] != tail[i]) r = 1'b0;
      return r;
   endfunction

   task automatic run_idle(input int limit);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done && n < limit) begin
         tick();
         n++;
         done = idle_now();
      end
      check("drain", 32'(done), 1);
      for (int i = 0; i < NR; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      expq.delete();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      for (int i = 0; i < NR; i++) begin
         head[i] = 0;
         tail[i] = 0;
         gap_run[i] = 0;
      end
      gap_now      = '0;
      expq.delete();
      bcnt         = 0;
      uart_tx_busy = 1'b0;
      mptr         = 0;
      exp_abort    = -1;
      arm_abort    = 0;
      last_data    = '0;
      drive();
      tick();
      tick();
      resetn = 1'b1;
   endtask

   initial begin
      int  cnt1;
      bit  got;
      req_valid    = '0;
      req_data     = '0;
      req_last     = '0;
      uart_tx_busy = 1'b0;
      for (int i = 0; i < NR; i++) begin
         head[i] = 0;
         tail[i] = 0;
         gap_run[i] = 0;
      end

      // Reset state, with a request pending to show ready stays low
      push(0, 8'h77, 1'b1);
      drive();
      #12;
      check("rst_grant", 32'(grant), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_abort", 32'(pkt_abort), 0);
      check("rst_en", 32'(uart_tx_en), 0);
      check("rst_data", 32'(uart_tx_data), 0);
      head[0] = 0;
      tail[0] = 0;
      drive();
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // Single byte from requester 0, latency from idle
      push(0, 8'hA5, 1'b1);
      plan();
      drive();
      tick();
      check("t1_grant_c0", 32'(s_grant), 0);
      tick();
      check("t1_grant_c1", 32'(s_grant), 32'h1);
      check("t1_ready_c1", 32'(s_ready), 32'h1);
      tick();
      check("t1_en_c2", 32'(s_en), 1);
      run_idle(200);
      // ptr is now 1: requester 1 wins over requester 0
      push(0, 8'h10, 1'b1);
      push(1, 8'h21, 1'b1);
      plan();
      drive();
      run_idle(200);

      // Requesters 0 and 2 from reset, twice (ptr 3 wraps to 0)
      do_reset();
      push(0, 8'h01, 1'b1);
      push(2, 8'h02, 1'b1);
      plan();
      drive();
      run_idle(200);
      push(0, 8'h03, 1'b1);
      push(2, 8'h04, 1'b1);
      plan();
      drive();
      run_idle(200);

      // Locked 3-byte packet from requester 1 while requester 3 waits
      do_reset();
      sg_log.delete();
      push(1, 8'h11, 1'b0);
      push(1, 8'h22, 1'b0);
      push(1, 8'h33, 1'b1);
      push(3, 8'h3C, 1'b1);
      plan();
      drive();
      run_idle(300);
      cnt1 = 0;
      foreach (sg_log[k]) if (sg_log[k] == 4'b0010) cnt1++;
      check("t3_req1_strobes", cnt1, 3);
      check("t3_total_strobes", sg_log.size(), 4);

      // Timeout: requester 2 sends a non-last byte and goes quiet
      push(2, 8'h5A, 1'b0);
      plan();
      arm_abort = 1;
      drive();
      run_idle(300);
      // ptr is now 3: requester 3 wins over requester 0
      push(0, 8'h0A, 1'b1);
      push(3, 8'h3A, 1'b1);
      plan();
      drive();
      run_idle(200);

      // Asynchronous reset while waiting for busy to fall mid-packet
      blen = 10;
      push(2, 8'h51, 1'b0);
      push(2, 8'h52, 1'b0);
      push(2, 8'h53, 1'b1);
      plan();
      drive();
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         tick();
         got = s_en;
      end
      check("t5_first_strobe", 32'(got), 1);
      for (int n = 0; n < 4; n++) tick();
      #2;
      resetn = 1'b0;
      #1;
      check("t5_grant", 32'(grant), 0);
      check("t5_ready", 32'(req_ready), 0);
      check("t5_en", 32'(uart_tx_en), 0);
      check("t5_data", 32'(uart_tx_data), 0);
      check("t5_abort", 32'(pkt_abort), 0);
      blen = 3;
      do_reset();
      // ptr back to 0: requester 0 wins over requester 2
      push(0, 8'h0B, 1'b1);
      push(2, 8'h2B, 1'b1);
      plan();
      drive();
      run_idle(200);

      // Long busy: next strobe exactly two cycles after busy falls
      blen = 50;
      sg_log.delete();
      pkt_strobes = 0;
      lat_chk = 1;
      push(1, 8'h61, 1'b0);
      push(1, 8'h62, 1'b1);
      plan();
      drive();
      run_idle(400);
      lat_chk = 0;
      check("t6_strobes", sg_log.size(), 2);
      blen = 3;

      // Random packets, random busy lengths, short mid-packet valid gaps
      gaps_on = 1;
      blen_rand = 1;
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < NR; i++) begin
            int np;
            np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) begin
               int len;
               len = $urandom_range(1, 4);
               for (int b = 0; b < len; b++) push(i, 8'($urandom), 1'(b == len - 1));
            end
         end
         plan();
         drive();
         run_idle(3000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
